// File: rtl/mips_pc_pkg.sv
// Shared types and defaults for the MIPS next-PC controller.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_JUMP,
    SEL_BR,
    SEL_PEND,
    SEL_SEQ
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational priority select of the next fetch address candidate.
module next_pc_mux
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        exc,
  input  logic        eret,
  input  logic        jump,
  input  logic        br_taken,
  input  logic        pend_valid,
  input  logic [31:0] br_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] epc,
  input  logic [31:0] pend_pc,
  input  logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output pc_sel_e     sel
);

  always_comb begin
    next_pc = pc_plus4;
    sel     = SEL_SEQ;
    if (exc) begin
      next_pc = EXC_VECTOR;
      sel     = SEL_EXC;
    end else if (eret) begin
      next_pc = word_align(epc);
      sel     = SEL_ERET;
    end else if (jump) begin
      next_pc = word_align(jump_target);
      sel     = SEL_JUMP;
    end else if (br_taken) begin
      next_pc = word_align(br_target);
      sel     = SEL_BR;
    end else if (pend_valid) begin
      next_pc = pend_pc;
      sel     = SEL_PEND;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register, fetch-request valid and redirect sequencing.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        if_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc,
  input  logic [31:0] epc_in,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        redirect,
  output logic [31:0] epc
);

  pc_state_e   state;
  pc_sel_e     sel;
  logic [31:0] pend_pc;
  logic [31:0] next_pc;
  logic        adv;

  assign pc_plus4 = pc + 32'd4;
  assign adv      = if_valid & if_ready & ~stall;

  next_pc_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_mux (
    .exc         (exc),
    .eret        (eret),
    .jump        (jump),
    .br_taken    (br_taken),
    .pend_valid  (state == PEND),
    .br_target   (br_target),
    .jump_target (jump_target),
    .epc         (epc),
    .pend_pc     (pend_pc),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc),
    .sel         (sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      epc      <= '0;
      pend_pc  <= '0;
      if_valid <= 1'b0;
      redirect <= 1'b0;
      state    <= BOOT;
    end else begin
      redirect <= 1'b0;
      if_valid <= 1'b1;
      case (sel)
        SEL_EXC: begin
          pc       <= next_pc;
          epc      <= epc_in;
          redirect <= 1'b1;
          state    <= RUN;
        end
        SEL_ERET: begin
          pc       <= next_pc;
          redirect <= 1'b1;
          state    <= RUN;
        end
        // A blocked jump/branch parks in pend_pc; a newer one overwrites it.
        SEL_JUMP, SEL_BR: begin
          if (adv) begin
            pc       <= next_pc;
            redirect <= 1'b1;
            state    <= RUN;
          end else begin
            pend_pc <= next_pc;
            state   <= PEND;
          end
        end
        SEL_PEND: begin
          if (adv) begin
            pc       <= next_pc;
            redirect <= 1'b1;
            state    <= RUN;
          end
        end
        default: begin
          if (adv) pc <= next_pc;
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller that owns the program-counter register and the instruction-fetch request for the MIPS core. It sequences sequential fetch, branch, jump and jr redirects, exception entry and eret return. It arbitrates these redirects against hazard stalls and instruction-memory back-pressure. It latches redirects that cannot take effect immediately so that none are lost.

Parameters:
RESET_PC, 32'h0000_3000, fetch address loaded on reset
EXC_VECTOR, 32'h0000_4180, exception handler entry address

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hazard-unit hold; blocks sequential advance
if_ready  in  1  instruction memory accepts the current fetch
br_taken  in  1  branch resolved taken in ID
br_target  in  32  branch destination
jump  in  1  j/jal/jr resolved in ID
jump_target  in  32  jump destination; the register value for jr
exc  in  1  exception request
epc_in  in  32  PC of the faulting instruction
eret  in  1  return from exception
pc  out  32  current fetch address
pc_plus4  out  32  pc + 4, modulo 2^32
if_valid  out  1  pc is a valid fetch request
redirect  out  1  1-cycle pulse; IF/ID must flush
epc  out  32  saved exception PC

Behaviour:
- Reset (synchronous, overrides everything, including mid-operation):
  - pc=RESET_PC, epc=0, if_valid=0, redirect=0, pending slot cleared, state=BOOT.
- State machine: BOOT, RUN, PEND.
  - BOOT -> RUN after one cycle (if_valid=0 in BOOT, then 1 from RUN onward).
  - RUN -> PEND when a jump/branch redirect arrives while the advance condition adv is false.
  - PEND -> RUN when adv is true; pc <= pend_pc and redirect=1.
- adv = if_valid & if_ready & ~stall.
- Next-PC priority, highest first: exc > eret > jump > br_taken > pending > sequential.
- exc:
  - pc <= EXC_VECTOR and epc <= epc_in immediately, regardless of stall or if_ready (the outstanding fetch is abandoned).
  - Pending slot cleared; state -> RUN; redirect=1.
- eret (no exc):
  - pc <= epc immediately, regardless of stall or if_ready.
  - Pending slot cleared; redirect=1.
- jump or br_taken, when adv:
  - pc <= target; redirect=1.
  - jump beats br_taken when both are asserted.
- jump or br_taken, when !adv:
  - pend_pc <= target; state PEND; pc holds; redirect=0.
  - A later jump/branch while in PEND overwrites pend_pc.
- Sequential, when adv in RUN with no redirect: pc <= pc_plus4.
- No adv and no immediate redirect: pc, epc and state hold.
- Targets: bits [1:0] are forced to 00 before loading (pc is always word-aligned).
- Arithmetic:
  - pc_plus4 is combinational, 32-bit, with wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
  - No other arithmetic.
- redirect is registered, high exactly in the cycle pc first shows a non-sequential value; it is never high two cycles in a row for a single event.
- epc changes only on exc or rst.
- exc and eret in the same cycle: exc wins and eret is dropped.

Decomposition:
- Package mips_pc_pkg holds:
  - the state enum (BOOT/RUN/PEND),
  - the next-PC select enum (SEL_EXC, SEL_ERET, SEL_JUMP, SEL_BR, SEL_PEND, SEL_SEQ),
  - the default RESET_PC and EXC_VECTOR constants.
- One sub-module, next_pc_mux: a purely combinational priority select producing the next pc and the select code. pc_sequencer keeps all registers and the FSM.

Test Plan:
- Reset then release, if_ready=1, stall=0 -> pc=0x3000 with if_valid=0 for one cycle, then if_valid=1 and pc steps 0x3000, 0x3004, 0x3008.
- At pc=0x3008 with stall=1 for 2 cycles, pulse br_taken with br_target=0x3040 in the first stall cycle:
  - pc holds 0x3008 and state is PEND;
  - after stall drops, next pc=0x3040 with redirect=1 for one cycle, then 0x3044.
- exc with epc_in=0x3010 while if_ready=0 -> next cycle pc=0x4180, epc=0x3010, redirect=1. eret later -> pc=0x3010.
- jump (target 0x3100) and br_taken (target 0x3200) in the same adv cycle -> pc=0x3100. exc and eret in the same cycle -> pc=0x4180 and epc updated.
- Pending branch to 0x3080, then rst asserted before adv -> pc=0x3000, state BOOT, pending discarded (pc never shows 0x3080).
- Force pc=0xFFFF_FFFC via jump, adv -> pc_plus4 reads 0x0000_0000 and next pc=0x0000_0000. A jump_target of 0x3103 loads 0x3100.
